kypd_key_event_ctrl: RTL and testbench

- Sequences the raw hex key stream from the keypad decoder into discrete key events.
- Qualifies presses and releases over a hold time, optionally generates typematic auto-repeat, and buffers events in a small FWFT FIFO.
- Consumers read the FIFO through a valid/ready handshake.
- Sits between the keypad decoder and any consumer (UART bridge, CPU register file, display logic).

---
 rtl/kypd_key_event_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_kypd_key_event_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/kypd_key_event_ctrl.sv
// Keypad key-event sequencer: qualifies presses/releases, optional typematic repeat
// (compile with KYPD_AUTO_REPEAT_EN), and queues events in a small FWFT FIFO.
module kypd_key_event_ctrl #(
    parameter real ClockFrequencyInMHz = 100.0,
    parameter real QualifyTimeInMs     = 5.0,
    parameter real RepeatDelayInMs     = 500.0,
    parameter real RepeatPeriodInMs    = 100.0,
    parameter int  FifoDepth           = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [3:0]                   key_code_i,
    input  logic                         key_active_i,
    output logic [3:0]                   evt_code_o,
    output logic                         evt_repeat_o,
    output logic                         evt_valid_o,
    input  logic                         evt_ready_i,
    output logic [$clog2(FifoDepth):0]   fifo_level_o,
    output logic                         overflow_o,
    input  logic                         overflow_clr_i
);

    localparam int Q_RAW = $rtoi(ClockFrequencyInMHz * 1000.0 * QualifyTimeInMs + 0.5);
    localparam int D_RAW = $rtoi(ClockFrequencyInMHz * 1000.0 * RepeatDelayInMs + 0.5);
    localparam int P_RAW = $rtoi(ClockFrequencyInMHz * 1000.0 * RepeatPeriodInMs + 0.5);
    localparam int Q     = (Q_RAW < 1) ? 1 : Q_RAW;
    localparam int D     = (D_RAW < 1) ? 1 : D_RAW;
    localparam int P     = (P_RAW < 1) ? 1 : P_RAW;
    localparam int MAX_QD = (Q > D) ? Q : D;
    localparam int MAXC   = (MAX_QD > P) ? MAX_QD : P;
    localparam int CW     = $clog2(MAXC + 1);
    localparam int AW     = $clog2(FifoDepth);

    localparam logic [CW-1:0] Q_LAST = CW'(Q - 1);
`ifdef KYPD_AUTO_REPEAT_EN
    localparam logic [CW-1:0] D_LAST = CW'(D - 1);
    localparam logic [CW-1:0] P_LAST = CW'(P - 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_QUALIFY = 3'd1,
        ST_HELD    = 3'd2,
`ifdef KYPD_AUTO_REPEAT_EN
        ST_REPEAT  = 3'd3,
`endif
        ST_RELEASE = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_timer;
    logic [3:0]      r_cand;
    logic            w_match;
    logic            w_timer_clr;
    logic            w_latch;
    logic            w_push;
    logic            w_push_rep;

    assign w_match = key_active_i && (key_code_i == r_cand);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_cand  <= 4'h0;
        end else begin
            r_state <= w_state_next;
            // The shared timer restarts on every state change and on explicit clears.
            if ((w_state_next != r_state) || w_timer_clr)
                r_timer <= '0;
            else
                r_timer <= r_timer + 1'b1;
            if (w_latch)
                r_cand <= key_code_i;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_timer_clr  = 1'b0;
        w_latch      = 1'b0;
        w_push       = 1'b0;
        w_push_rep   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_timer_clr = 1'b1;
                if (key_active_i) begin
                    w_latch      = 1'b1;
                    w_state_next = ST_QUALIFY;
                end
            end
            ST_QUALIFY: begin
                if (!w_match) begin
                    w_state_next = ST_IDLE;
                end else if (r_timer == Q_LAST) begin
                    w_push       = 1'b1;
                    w_state_next = ST_HELD;
                end
            end
            ST_HELD: begin
                if (!w_match) begin
                    w_state_next = ST_RELEASE;
`ifdef KYPD_AUTO_REPEAT_EN
                end else if (r_timer == D_LAST) begin
                    w_push       = 1'b1;
                    w_push_rep   = 1'b1;
                    w_state_next = ST_REPEAT;
                end
`else
                end else begin
                    w_timer_clr = 1'b1;
                end
`endif
            end
`ifdef KYPD_AUTO_REPEAT_EN
            ST_REPEAT: begin
                if (!w_match) begin
                    w_state_next = ST_RELEASE;
                end else if (r_timer == P_LAST) begin
                    w_push      = 1'b1;
                    w_push_rep  = 1'b1;
                    w_timer_clr = 1'b1;
                end
            end
`endif
            ST_RELEASE: begin
                // Any activity (even a different key) restarts the quiet window.
                if (key_active_i)
                    w_timer_clr = 1'b1;
                else if (r_timer == Q_LAST)
                    w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    logic [3:0]      r_mem_code [FifoDepth];
`ifdef KYPD_AUTO_REPEAT_EN
    logic            r_mem_rep  [FifoDepth];
`endif
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            r_overflow;
    logic            w_full;
    logic            w_valid;
    logic            w_pop;
    logic            w_wr;
    logic            w_drop;

    assign w_full  = (r_count == (AW+1)'(FifoDepth));
    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && evt_ready_i;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_mem_code[r_wr_ptr] <= r_cand;
`ifdef KYPD_AUTO_REPEAT_EN
            r_mem_rep[r_wr_ptr]  <= w_push_rep;
`endif
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop)
                r_overflow <= 1'b1;
            else if (overflow_clr_i)
                r_overflow <= 1'b0;
        end
    end

    assign evt_valid_o  = w_valid;
    assign evt_code_o   = w_valid ? r_mem_code[r_rd_ptr] : 4'h0;
`ifdef KYPD_AUTO_REPEAT_EN
    assign evt_repeat_o = w_valid ? r_mem_rep[r_rd_ptr] : 1'b0;
`else
    assign evt_repeat_o = 1'b0;
`endif
    assign fifo_level_o = r_count;
    assign overflow_o   = r_overflow;

endmodule

// File: tb/tb_kypd_key_event_ctrl.sv
// Directed bench for kypd_key_event_ctrl at 1 cycle per ms (Q=5, D=20, P=10, depth 4).
// Expectations follow KYPD_AUTO_REPEAT_EN when the bench is built with it.
module tb_kypd_key_event_ctrl;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic [3:0] key_code_i;
    logic       key_active_i;
    logic [3:0] evt_code_o;
    logic       evt_repeat_o;
    logic       evt_valid_o;
    logic       evt_ready_i;
    logic [2:0] fifo_level_o;
    logic       overflow_o;
    logic       overflow_clr_i;

    int n_checks = 0;
    int n_fail   = 0;

    kypd_key_event_ctrl #(
        .ClockFrequencyInMHz (0.001),
        .QualifyTimeInMs     (5.0),
        .RepeatDelayInMs     (20.0),
        .RepeatPeriodInMs    (10.0),
        .FifoDepth           (4)
    ) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .key_code_i     (key_code_i),
        .key_active_i   (key_active_i),
        .evt_code_o     (evt_code_o),
        .evt_repeat_o   (evt_repeat_o),
        .evt_valid_o    (evt_valid_o),
        .evt_ready_i    (evt_ready_i),
        .fifo_level_o   (fifo_level_o),
        .overflow_o     (overflow_o),
        .overflow_clr_i (overflow_clr_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic press(input logic [3:0] c, input int hold, input int gap);
        key_code_i   = c;
        key_active_i = 1'b1;
        step(hold);
        key_active_i = 1'b0;
        step(gap);
    endtask

    task automatic pop_check(input string tag, input logic [3:0] c, input logic rep);
        chk({tag, "_valid"}, evt_valid_o, 1'b1);
        chk({tag, "_code"}, evt_code_o, c);
        chk({tag, "_rep"}, evt_repeat_o, rep);
        $display("EVT %s code=%0h rep=%0b level=%0d", tag, evt_code_o, evt_repeat_o, fifo_level_o);
        evt_ready_i = 1'b1;
        step(1);
        evt_ready_i = 1'b0;
    endtask

    initial begin
        reset_i        = 1'b1;
        key_code_i     = 4'h0;
        key_active_i   = 1'b0;
        evt_ready_i    = 1'b0;
        overflow_clr_i = 1'b0;
        step(2);
        chk("rst_valid", evt_valid_o, 1'b0);
        chk("rst_code", evt_code_o, 4'h0);
        chk("rst_rep", evt_repeat_o, 1'b0);
        chk("rst_level", fifo_level_o, 3'd0);
        chk("rst_ovf", overflow_o, 1'b0);
        reset_i = 1'b0;
        step(1);

        // Short press of 4 cycles never qualifies.
        key_code_i   = 4'h7;
        key_active_i = 1'b1;
        step(4);
        key_active_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("short_valid", evt_valid_o, 1'b0);
            step(1);
        end

        // Single press with a ready consumer: event visible exactly 6 cycles after rise.
        evt_ready_i  = 1'b1;
        key_code_i   = 4'hA;
        key_active_i = 1'b1;
        step(5);
        chk("a_early_valid", evt_valid_o, 1'b0);
        step(1);
        chk("a_valid", evt_valid_o, 1'b1);
        chk("a_code", evt_code_o, 4'hA);
        chk("a_rep", evt_repeat_o, 1'b0);
        $display("EVT a code=%0h rep=%0b", evt_code_o, evt_repeat_o);
        step(1);
        chk("a_popped_valid", evt_valid_o, 1'b0);
        chk("a_popped_level", fifo_level_o, 3'd0);
        step(5);
        key_active_i = 1'b0;
        step(10);
        chk("a_after_valid", evt_valid_o, 1'b0);
        evt_ready_i = 1'b0;

        // Long hold of 0x3 for 50 cycles.
        key_code_i   = 4'h3;
        key_active_i = 1'b1;
        step(6);
        chk("h_lvl6", fifo_level_o, 3'd1);
        chk("h_code6", evt_code_o, 4'h3);
        step(19);
        chk("h_lvl25", fifo_level_o, 3'd1);
        step(1);
`ifdef KYPD_AUTO_REPEAT_EN
        chk("h_lvl26", fifo_level_o, 3'd2);
        step(10);
        chk("h_lvl36", fifo_level_o, 3'd3);
        step(10);
        chk("h_lvl46", fifo_level_o, 3'd4);
`else
        chk("h_lvl26", fifo_level_o, 3'd1);
        step(10);
        chk("h_lvl36", fifo_level_o, 3'd1);
        step(10);
        chk("h_lvl46", fifo_level_o, 3'd1);
`endif
        step(4);
        key_active_i = 1'b0;
        step(10);
        chk("h_ovf", overflow_o, 1'b0);
        pop_check("h0", 4'h3, 1'b0);
`ifdef KYPD_AUTO_REPEAT_EN
        pop_check("h1", 4'h3, 1'b1);
        pop_check("h2", 4'h3, 1'b1);
        pop_check("h3", 4'h3, 1'b1);
`endif
        chk("h_empty", evt_valid_o, 1'b0);

        // Overflow: five presses with no consumer.
        for (int c = 1; c <= 4; c++) press(4'(c), 7, 8);
        chk("of_lvl4", fifo_level_o, 3'd4);
        chk("of_ovf_pre", overflow_o, 1'b0);
        press(4'h5, 7, 8);
        chk("of_lvl_full", fifo_level_o, 3'd4);
        chk("of_ovf", overflow_o, 1'b1);
        chk("of_head", evt_code_o, 4'h1);
        pop_check("of1", 4'h1, 1'b0);
        pop_check("of2", 4'h2, 1'b0);
        pop_check("of3", 4'h3, 1'b0);
        pop_check("of4", 4'h4, 1'b0);
        chk("of_empty", evt_valid_o, 1'b0);
        chk("of_sticky", overflow_o, 1'b1);
        overflow_clr_i = 1'b1;
        step(1);
        overflow_clr_i = 1'b0;
        chk("of_clr", overflow_o, 1'b0);

        // Full FIFO with simultaneous push and pop.
        for (int c = 1; c <= 4; c++) press(4'(c), 7, 8);
        chk("pp_lvl_pre", fifo_level_o, 3'd4);
        key_code_i   = 4'h5;
        key_active_i = 1'b1;
        step(5);
        evt_ready_i = 1'b1;
        chk("pp_head_pre", evt_code_o, 4'h1);
        step(1);
        evt_ready_i = 1'b0;
        chk("pp_lvl", fifo_level_o, 3'd4);
        chk("pp_ovf", overflow_o, 1'b0);
        chk("pp_head", evt_code_o, 4'h2);
        key_active_i = 1'b0;
        step(8);
        pop_check("pp2", 4'h2, 1'b0);
        pop_check("pp3", 4'h3, 1'b0);
        pop_check("pp4", 4'h4, 1'b0);
        pop_check("pp5", 4'h5, 1'b0);

        // Asynchronous reset with two entries queued while a key is held.
`ifdef KYPD_AUTO_REPEAT_EN
        key_code_i   = 4'h6;
        key_active_i = 1'b1;
        step(28);
`else
        press(4'h9, 7, 8);
        key_code_i   = 4'h6;
        key_active_i = 1'b1;
        step(8);
`endif
        chk("ar_lvl_pre", fifo_level_o, 3'd2);
        #2;
        reset_i = 1'b1;
        #1;
        chk("ar_valid", evt_valid_o, 1'b0);
        chk("ar_code", evt_code_o, 4'h0);
        chk("ar_rep", evt_repeat_o, 1'b0);
        chk("ar_level", fifo_level_o, 3'd0);
        chk("ar_ovf", overflow_o, 1'b0);
        step(2);
        reset_i = 1'b0;
        step(5);
        chk("ar_requal_early", evt_valid_o, 1'b0);
        step(1);
        chk("ar_requal_valid", evt_valid_o, 1'b1);
        chk("ar_requal_code", evt_code_o, 4'h6);
        chk("ar_requal_rep", evt_repeat_o, 1'b0);
        chk("ar_requal_lvl", fifo_level_o, 3'd1);
        key_active_i = 1'b0;
        step(4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
